// File: rtl/norm_lzc_ctrl.sv
// Normalisation control for the FP add/sub datapath: carry pre-shift or multi-cycle
// nibble leading-zero scan, producing shift amount, mantissa, exponent and flags.
module norm_lzc_ctrl #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic              guard_out,
  output logic              zero_out,
  output logic              denorm_out,
  output logic              ovf_out
);

  localparam int NIB = MANT_W / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW  = (EXP_W > SEL_W) ? EXP_W : SEL_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_reg, state_next;

  logic [MANT_W-1:0] mant_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic              sign_reg;
  logic [KW-1:0]     k_reg;

  logic [SEL_W-1:0]  sel_reg;
  logic [MANT_W-1:0] mant_out_reg;
  logic [EXP_W-1:0]  exp_out_reg;
  logic              guard_reg;
  logic              zero_reg;
  logic              denorm_reg;
  logic              ovf_reg;

  // Nibble table padded to a power of two so any k value indexes safely.
  logic [3:0] nibs [2**KW];

  generate
    for (genvar gi = 0; gi < 2**KW; gi++) begin : g_nibs
      if (gi < NIB) begin : g_real
        assign nibs[gi] = mant_reg[MANT_W-1-4*gi -: 4];
      end else begin : g_pad
        assign nibs[gi] = 4'h0;
      end
    end
  endgenerate

  logic [3:0]       nib;
  logic [1:0]       nib_lz;
  logic [SEL_W-1:0] lz;
  logic             last_nib;
  logic [CW-1:0]    lz_c;
  logic [CW-1:0]    exp_c;
  logic [SEL_W-1:0] norm_sel;
  logic [EXP_W-1:0] norm_exp;
  logic             norm_den;
  logic [EXP_W-1:0] exp_inc;
  logic             carry_ovf;
  logic [EXP_W-1:0] carry_exp;

  always_comb begin
    nib      = nibs[k_reg];
    nib_lz   = 2'd3;
    if (nib[3])      nib_lz = 2'd0;
    else if (nib[2]) nib_lz = 2'd1;
    else if (nib[1]) nib_lz = 2'd2;
    lz       = SEL_W'({k_reg, 2'b00}) + SEL_W'(nib_lz);
    last_nib = (k_reg == KW'(NIB - 1));
    lz_c     = CW'(lz);
    exp_c    = CW'(exp_reg);
  end

  // Shift clamps at exp-1 so the result lands exactly on the subnormal exponent.
  always_comb begin
    norm_sel = '0;
    norm_exp = '0;
    norm_den = 1'b0;
    if (exp_reg == '0) begin
      norm_den = 1'b1;
    end else if (lz_c < exp_c) begin
      norm_sel = lz;
      norm_exp = exp_reg - EXP_W'(lz_c);
    end else begin
      norm_sel = SEL_W'(exp_c - CW'(1));
      norm_den = 1'b1;
    end
  end

  always_comb begin
    exp_inc   = exp_in + EXP_W'(1);
    carry_ovf = (exp_in == EXP_MAX) || (exp_inc == EXP_MAX);
    carry_exp = carry_ovf ? EXP_MAX : exp_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = mant_in[MANT_W] ? DONE : SCAN;
      SCAN: if (nib != 4'h0 || last_nib) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_reg     <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      k_reg        <= '0;
      sel_reg      <= '0;
      mant_out_reg <= '0;
      exp_out_reg  <= '0;
      guard_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      denorm_reg   <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mant_reg <= mant_in[MANT_W-1:0];
            exp_reg  <= exp_in;
            sign_reg <= sign_in;
            k_reg    <= '0;
            if (mant_in[MANT_W]) begin
              sel_reg      <= '0;
              mant_out_reg <= mant_in[MANT_W:1];
              guard_reg    <= mant_in[0];
              exp_out_reg  <= carry_exp;
              ovf_reg      <= carry_ovf;
              zero_reg     <= 1'b0;
              denorm_reg   <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (nib != 4'h0) begin
            sel_reg      <= norm_sel;
            mant_out_reg <= mant_reg;
            exp_out_reg  <= norm_exp;
            denorm_reg   <= norm_den;
            guard_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
          end else if (last_nib) begin
            sel_reg      <= '0;
            mant_out_reg <= mant_reg;
            exp_out_reg  <= '0;
            zero_reg     <= 1'b1;
            denorm_reg   <= 1'b0;
            guard_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            sel_reg      <= '0;
            mant_out_reg <= '0;
            exp_out_reg  <= '0;
            guard_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            denorm_reg   <= 1'b0;
            ovf_reg      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign sel        = sel_reg;
  assign mant_out   = mant_out_reg;
  assign exp_out    = exp_out_reg;
  assign sign_out   = sign_reg;
  assign guard_out  = guard_reg;
  assign zero_out   = zero_reg;
  assign denorm_out = denorm_reg;
  assign ovf_out    = ovf_reg;

endmodule
